// File: rtl/pipe_pkg.sv
// Shared types and default widths for the two-entry pipeline stage.
// Imported by the stage, its counter and its handshake interface.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    // Entry count is the state encoding itself.
    function automatic logic [1:0] occ_of(state_e s);
        return logic'(s == FULL) ? 2'd2 : (s == BUSY ? 2'd1 : 2'd0);
    endfunction

endpackage

// File: rtl/pipe_stage_if.sv
// Valid/ready handshake bundle for one pipeline stage.
// master = upstream producer and downstream consumer; slave = the stage.
interface pipe_stage_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;

    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );
endinterface

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
// Used to count bubble cycles at the stage output.
module pipe_sat_cnt
    import pipe_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: step by one unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stage.sv
// Two-entry (main + skid) pipeline stage with stall, flush and
// a bubble counter; in_ready_o depends on registered state only.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [1:0]        occ_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);
    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [CTRL_W-1:0] mctl_q, mctl_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [CTRL_W-1:0] sctl_q, sctl_d;
    logic              in_fire, out_fire;

    assign in_ready_o  = (state_q != FULL);
    assign out_valid_o = (state_q != EMPTY);
    assign occ_o       = occ_of(state_q);
    assign out_data_o  = main_q;
    assign out_ctrl_o  = out_valid_o ? mctl_q : '0;

    assign in_fire  = in_valid_i & in_ready_o & ~stall_i;
    assign out_fire = out_valid_o & out_ready_i & ~stall_i;

    // Next-state and entry movement; flush beats everything else.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        mctl_d  = mctl_q;
        skid_d  = skid_q;
        sctl_d  = sctl_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = BUSY;
                        main_d  = in_data_i;
                        mctl_d  = in_ctrl_i;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data_i;
                        mctl_d = in_ctrl_i;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = in_data_i;
                        sctl_d  = in_ctrl_i;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = BUSY;
                        main_d  = skid_q;
                        mctl_d  = sctl_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and entry registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= EMPTY;
            main_q  <= '0;
            mctl_q  <= '0;
            skid_q  <= '0;
            sctl_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            mctl_q  <= mctl_d;
            skid_q  <= skid_d;
            sctl_q  <= sctl_d;
        end
    end

    pipe_sat_cnt #(
        .CNT_W(CNT_W)
    ) u_bubble (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .inc_i  (~out_valid_o),
        .cnt_o  (bubble_cnt_o)
    );
endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning payload width (data, pc, immediates).
REQ-002 SHALL have parameter CTRL_W, default 16, meaning width of the control field that is zeroed on a bubble.
REQ-003 SHALL have parameter CNT_W, default 16, meaning bubble-counter width.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n_i  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid_i  input  1  upstream has a stage word.
REQ-007 SHALL have port in_ready_o  output  1  stage can accept a word.
REQ-008 SHALL have port in_data_i  input  DATA_W  upstream payload.
REQ-009 SHALL have port in_ctrl_i  input  CTRL_W  upstream control bits (RegWrite, MemWrite, etc.).
REQ-010 SHALL have port out_valid_o  output  1  stage holds a word for downstream.
REQ-011 SHALL have port out_ready_i  input  1  downstream accepts.
REQ-012 SHALL have port out_data_o  output  DATA_W  head payload.
REQ-013 SHALL have port out_ctrl_o  output  CTRL_W  head control; zero when out_valid_o=0.
REQ-014 SHALL have port stall_i  input  1  hazard stall; freezes both transfers.
REQ-015 SHALL have port flush_i  input  1  squash all held words.
REQ-016 SHALL have port occ_o  output  2  entries held (0..2).
REQ-017 SHALL have port bubble_cnt_o  output  CNT_W  saturating count of cycles with out_valid_o=0.

Function
REQ-018 SHALL hold up to two words: a main entry (head) and a skid entry; states EMPTY, BUSY (main only), FULL (main+skid).
REQ-019 SHALL define in_fire = in_valid_i & in_ready_o & ~stall_i and out_fire = out_valid_o & out_ready_i & ~stall_i.
REQ-020 SHALL drive in_ready_o = (state != FULL), decoded from state only, with no combinational path from out_ready_i or stall_i.
REQ-021 SHALL drive out_valid_o = (state != EMPTY) and occ_o = 0/1/2 for EMPTY/BUSY/FULL.
REQ-022 SHALL, in EMPTY, go to BUSY on in_fire with main <= input; latency from input to out_valid_o is one cycle.
REQ-023 SHALL, in BUSY: on in_fire & out_fire stay BUSY with main <= input; on in_fire & ~out_fire go FULL with skid <= input; on ~in_fire & out_fire go EMPTY; otherwise hold.
REQ-024 SHALL, in FULL, go to BUSY on out_fire with main <= skid; no input is accepted in FULL.
REQ-025 SHALL, on stall_i=1 with flush_i=0, hold all state, entries and counters except bubble_cnt_o.
REQ-026 SHALL, on flush_i=1, go to EMPTY next edge, discarding main, skid and any same-cycle input; flush has priority over stall, in_fire and out_fire.
REQ-027 SHALL force out_ctrl_o to all-zero whenever out_valid_o=0; out_data_o retains the last main value.
REQ-028 SHALL preserve word order: no word is duplicated, dropped (except by flush) or reordered.
REQ-029 SHALL increment bubble_cnt_o by 1 each cycle out_valid_o=0, saturating at 2^CNT_W-1 without wrapping.

Reset
REQ-030 SHALL, on rst_n_i=0, immediately set state EMPTY, main, skid and bubble_cnt_o to zero, giving in_ready_o=1, out_valid_o=0, out_data_o=0, out_ctrl_o=0 and occ_o=0.
REQ-031 SHALL, on reset asserted mid-transfer, discard all held words; the first accept after rst_n_i rises is the next in_fire.

Structure
REQ-032 SHALL place the state enum (EMPTY/BUSY/FULL) and default DATA_W/CTRL_W/CNT_W constants in shared package pipe_pkg.
REQ-033 SHALL implement the saturating counter as sub-module pipe_sat_cnt (parameter CNT_W; ports clk_i, rst_n_i, inc_i, cnt_o).

Verification
REQ-034 SHALL verify reset: rst_n_i=0 mid-FULL -> next sample in_ready_o=1, out_valid_o=0, out_ctrl_o=0, occ_o=0.
REQ-035 SHALL verify streaming: out_ready_i=1, in_valid_i=1 with data 0x10..0x14 -> outputs appear in order one cycle later, occ_o stays 1.
REQ-036 SHALL verify backpressure: out_ready_i=0 and push 0xA, 0xB -> occ_o=2, in_ready_o=0; then out_ready_i=1 -> 0xA, then 0xB, with no loss.
REQ-037 SHALL verify stall: BUSY holding 0x55 with ctrl 0x00FF, stall_i=1 for 3 cycles while out_ready_i=1 and in_valid_i=1 -> 0x55 and ctrl 0x00FF held, nothing accepted, occ_o=1.
REQ-038 SHALL verify flush priority: FULL, with flush_i=1, stall_i=1 and in_valid_i=1 in the same cycle -> next cycle EMPTY, out_ctrl_o=0, input dropped.
REQ-039 SHALL verify saturation: CNT_W=4, idle for 20 cycles -> bubble_cnt_o=15 and held.
